// File: rtl/pc_mar_ram.sv
// Program counter, MAR, MDR and 16x8 program/data RAM for the SAP-style CPU.
// Define PC_MAR_RAM_CLEAR_EN to make rst clear every RAM word. Otherwise RAM keeps its contents across rst.
module pc_mar_ram (
   input  logic       clk,
   input  logic       rst,
   input  logic       pc_inc,
   input  logic       pc_en,
   input  logic       pc_load,
   input  logic       mar_load_n,
   input  logic       mdr_load_n,
   input  logic       ram_en_n,
   input  logic       ram_load_n,
   input  logic       prog_mode,
   input  logic       prog_we,
   input  logic [3:0] prog_addr,
   input  logic [7:0] prog_data,
   input  logic [7:0] bus_in,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   output logic [3:0] pc_q,
   output logic       bus_err
);

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic [AW-1:0] pc_reg, pc_next;
   logic [AW-1:0] mar_reg, mar_next;
   logic [DW-1:0] mdr_reg, mdr_next;
   logic          bus_err_reg, bus_err_next;
   logic          bus_conflict;

   logic [DW-1:0] ram_q [DEPTH];
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [DEPTH-1:0] word_we;

   // Programming mode freezes the datapath and hands the write port to the loader.
   always_comb begin
      pc_next      = pc_reg;
      mar_next     = mar_reg;
      mdr_next     = mdr_reg;
      bus_conflict = 1'b0;
      if (!prog_mode) begin
         if (pc_load)
            pc_next = bus_in[AW-1:0];
         else if (pc_inc)
            pc_next = pc_reg + 4'd1;
         if (!mar_load_n)
            mar_next = bus_in[AW-1:0];
         if (!mdr_load_n)
            mdr_next = bus_in;
         bus_conflict = pc_en && !ram_en_n;
      end
      bus_err_next = bus_err_reg | bus_conflict;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_reg      <= '0;
         mar_reg     <= '0;
         mdr_reg     <= '0;
         bus_err_reg <= 1'b0;
      end else begin
         pc_reg      <= pc_next;
         mar_reg     <= mar_next;
         mdr_reg     <= mdr_next;
         bus_err_reg <= bus_err_next;
      end
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = mar_reg;
      wr_data = mdr_reg;
      if (prog_mode) begin
         wr_en   = prog_we;
         wr_addr = prog_addr;
         wr_data = prog_data;
      end else begin
         wr_en   = !ram_load_n;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_word_we
         assign word_we[gi] = wr_en && (wr_addr == AW'(gi));
      end
   endgenerate

`ifdef PC_MAR_RAM_CLEAR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            ram_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (word_we[i])
               ram_q[i] <= wr_data;
      end
   end
`else
   // Contents survive rst, but a write is still suppressed while rst is high.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            if (word_we[i])
               ram_q[i] <= wr_data;
      end
   end
`endif

   // PC wins the bus over RAM; a read sees pre-edge MAR and RAM contents.
   always_comb begin
      bus_out = '0;
      bus_oe  = 1'b0;
      if (!rst && !prog_mode) begin
         if (pc_en) begin
            bus_out = {4'h0, pc_reg};
            bus_oe  = 1'b1;
         end else if (!ram_en_n) begin
            bus_out = ram_q[mar_reg];
            bus_oe  = 1'b1;
         end
      end
   end

   assign pc_q    = pc_reg;
   assign bus_err = bus_err_reg;

endmodule
